// File: rtl/mult_div_unit.sv
// mult_div_unit
//
// Iterative HI/LO multiply/divide unit for the MIPS datapath. It works on
// operand magnitudes: shift-add multiply or restoring divide, one bit per
// cycle. A final FIX cycle restores the signs for MULT/DIV, and the result is
// committed to the architectural HI/LO registers.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start, op      operation request (00 MULTU, 01 MULT, 10 DIVU, 11 DIV),
//                  sampled only in IDLE
//   rs_data        multiplicand / dividend / MTHI-MTLO source
//   rt_data        multiplier / divisor
//   mthi, mtlo     write rs_data into HI / LO (IDLE with start=0 only)
//   busy           operation in progress (MUL, DIV, FIX)
//   done           one-cycle pulse; HI/LO hold the new result
//   div_by_zero    one-cycle pulse with done for a divide by zero
//   hi, lo         architectural HI and LO registers

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 is_signed;
    logic                 rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    // Operand magnitudes and sign-restoration candidates. The magnitude of the
    // most negative value wraps to itself, which is exactly its unsigned
    // magnitude, so the overflow case needs no special handling.
    always_comb begin
        is_signed = op[0];
        rs_neg    = is_signed & rs_data[WIDTH-1];
        rt_neg    = is_signed & rt_data[WIDTH-1];
        rs_mag    = rs_neg ? -rs_data : rs_data;
        rt_mag    = rt_neg ? -rt_data : rt_data;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

        // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};

        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = op[1];
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    cnt_d     = '0;
                    if (op[1]) begin
                        opnd_d = rt_mag;
                        acc_d  = {{WIDTH{1'b0}}, rs_mag};
                        if (rt_data == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = DIV;
                        end
                    end else begin
                        opnd_d  = rs_mag;
                        acc_d   = {{WIDTH{1'b0}}, rt_mag};
                        state_d = MUL;
                    end
                end else begin
                    if (mthi) hi_d = rs_data;
                    if (mtlo) lo_d = rs_data;
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
            DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                // Sign restoration and HI/LO commit share this edge so the
                // registered hi/lo already show the result during DONE.
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MUL) || (state_d == DIV) || (state_d == FIX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
